// File: rtl/picosoc_iomux.sv
// iomem fabric: page-decoded master-to-slave routing with a per-access
// watchdog and error logging so unmapped or stalled slaves cannot hang the CPU.
module picosoc_iomux #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter logic [8*NUM_SLAVES-1:0] SLAVE_PAGES = {8'h06, 8'h05, 8'h04, 8'h03},
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       m_valid,
    output logic                       m_ready,
    input  logic [3:0]                 m_wstrb,
    input  logic [31:0]                m_addr,
    input  logic [31:0]                m_wdata,
    output logic [31:0]                m_rdata,
    output logic [NUM_SLAVES-1:0]      s_valid,
    input  logic [NUM_SLAVES-1:0]      s_ready,
    output logic [3:0]                 s_wstrb,
    output logic [31:0]                s_addr,
    output logic [31:0]                s_wdata,
    input  logic [32*NUM_SLAVES-1:0]   s_rdata,
    input  logic                       err_clear,
    output logic                       err_pulse,
    output logic [31:0]                err_addr,
    output logic [7:0]                 err_count
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RESP
    } state_e;

    state_e                state_q, state_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [NUM_SLAVES-1:0] s_valid_q, s_valid_d;
    logic [3:0]            s_wstrb_q, s_wstrb_d;
    logic [31:0]           s_addr_q, s_addr_d;
    logic [31:0]           s_wdata_q, s_wdata_d;
    logic [31:0]           m_rdata_q, m_rdata_d;
    logic                  err_pulse_q, err_pulse_d;
    logic [31:0]           err_addr_q, err_addr_d;
    logic [7:0]            err_count_q, err_count_d;

    logic                  hit;
    logic [SW-1:0]         hit_idx;
    logic                  sel_ready;
    logic [31:0]           sel_rdata;
    logic                  err_set;
    logic [7:0]            cnt_base;

    // Descending scan so the lowest matching index is the one left standing
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
            if (m_addr[31:24] == SLAVE_PAGES[8*i +: 8]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (sel_q == SW'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            timer_q     <= '0;
            s_valid_q   <= '0;
            s_wstrb_q   <= '0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            m_rdata_q   <= '0;
            err_pulse_q <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            timer_q     <= timer_d;
            s_valid_q   <= s_valid_d;
            s_wstrb_q   <= s_wstrb_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            m_rdata_q   <= m_rdata_d;
            err_pulse_q <= err_pulse_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        timer_d    = timer_q;
        s_valid_d  = s_valid_q;
        s_wstrb_d  = s_wstrb_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        m_rdata_d  = m_rdata_q;
        err_addr_d = err_addr_q;
        err_set    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (m_valid) begin
                    s_addr_d  = m_addr;
                    s_wdata_d = m_wdata;
                    s_wstrb_d = m_wstrb;
                    if (hit) begin
                        s_valid_d = NUM_SLAVES'(1) << hit_idx;
                        sel_d     = hit_idx;
                        timer_d   = '0;
                        state_d   = ACTIVE;
                    end else begin
                        m_rdata_d  = ERR_RDATA;
                        err_set    = 1'b1;
                        err_addr_d = m_addr;
                        state_d    = RESP;
                    end
                end
            end
            ACTIVE: begin
                timer_d = timer_q + 1'b1;
                if (sel_ready) begin
                    m_rdata_d = sel_rdata;
                    s_valid_d = '0;
                    state_d   = RESP;
                end else if (timer_q == TLAST) begin
                    s_valid_d  = '0;
                    m_rdata_d  = ERR_RDATA;
                    err_set    = 1'b1;
                    err_addr_d = s_addr_q;
                    state_d    = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Clear is applied before the increment so a coincident error counts as 1
    always_comb begin
        cnt_base    = err_clear ? 8'h00 : err_count_q;
        err_count_d = cnt_base;
        if (err_set) begin
            err_count_d = cnt_base + {7'b0, cnt_base != 8'hFF};
        end
        err_pulse_d = err_set;
    end

    always_comb begin
        m_ready   = (state_q == RESP);
        m_rdata   = m_rdata_q;
        s_valid   = s_valid_q;
        s_wstrb   = s_wstrb_q;
        s_addr    = s_addr_q;
        s_wdata   = s_wdata_q;
        err_pulse = err_pulse_q;
        err_addr  = err_addr_q;
        err_count = err_count_q;
    end

endmodule

// File: tb/tb_picosoc_iomux.sv
// Directed bench for picosoc_iomux: vector table of single accesses plus
// hand sequences for error saturation, clear and mid-transaction reset.
module tb_picosoc_iomux;

    localparam int NS = 4;
    localparam int TO = 8;

    logic          clk;
    logic          reset;
    logic          m_valid;
    logic          m_ready;
    logic [3:0]    m_wstrb;
    logic [31:0]   m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;
    logic [NS-1:0] s_valid;
    logic [NS-1:0] s_ready;
    logic [3:0]    s_wstrb;
    logic [31:0]   s_addr;
    logic [31:0]   s_wdata;
    logic [32*NS-1:0] s_rdata;
    logic          err_clear;
    logic          err_pulse;
    logic [31:0]   err_addr;
    logic [7:0]    err_count;

    picosoc_iomux #(
        .NUM_SLAVES(NS),
        .SLAVE_PAGES(32'h0605_0403),
        .TIMEOUT(TO),
        .ERR_RDATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk),
        .reset(reset),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_wstrb(m_wstrb),
        .m_addr(m_addr),
        .m_wdata(m_wdata),
        .m_rdata(m_rdata),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_wstrb(s_wstrb),
        .s_addr(s_addr),
        .s_wdata(s_wdata),
        .s_rdata(s_rdata),
        .err_clear(err_clear),
        .err_pulse(err_pulse),
        .err_addr(err_addr),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   addr;
        logic [3:0]    wstrb;
        logic [31:0]   wdata;
        int            rdy;
        int            sl;
        logic [NS-1:0] noise;
        logic [31:0]   srd;
        logic [NS-1:0] exp_sv;
        logic [31:0]   exp_rd;
        int            exp_lat;
        int            exp_act;
        bit            exp_err;
    } vec_t;

    vec_t vecs[9];
    int   n_err = 0;
    int   n_chk = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_txn(input vec_t v);
        int cyc;
        int act;
        logic [NS-1:0] svs;
        bit done;
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = v.addr;
        m_wstrb = v.wstrb;
        m_wdata = v.wdata;
        cyc  = 0;
        act  = 0;
        svs  = '0;
        done = 1'b0;
        @(posedge clk);
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (m_ready) begin
                done = 1'b1;
            end else if (s_valid != '0) begin
                act++;
                svs |= s_valid;
                s_ready = v.noise;
                if (act == v.rdy) s_ready[v.sl] = 1'b1;
                for (int i = 0; i < NS; i++)
                    s_rdata[32*i +: 32] = (i == v.sl) ? v.srd : ~v.srd;
            end
        end
        s_ready = '0;
        m_valid = 1'b0;
        if (v.exp_err) exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
        chk("done", 32'(done), 32'd1);
        chk("latency", 32'(cyc), 32'(v.exp_lat));
        chk("active_cycles", 32'(act), 32'(v.exp_act));
        chk("s_valid_seen", 32'(svs), 32'(v.exp_sv));
        chk("m_rdata", m_rdata, v.exp_rd);
        chk("err_pulse", 32'(err_pulse), 32'(v.exp_err));
        chk("s_addr", s_addr, v.addr);
        chk("s_wstrb", 32'(s_wstrb), 32'(v.wstrb));
        chk("s_wdata", s_wdata, v.wdata);
        chk("err_count", 32'(err_count), 32'(exp_cnt));
        if (v.exp_err) chk("err_addr", err_addr, v.addr);
        @(negedge clk);
        chk("m_ready_one_cycle", 32'(m_ready), 32'd0);
        chk("err_pulse_one_cycle", 32'(err_pulse), 32'd0);
    endtask

    task automatic fast_unmapped();
        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = 32'h0900_0000;
        m_wstrb = 4'h0;
        @(negedge clk);
        m_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0400_0010, 4'h0, 32'h0, 3, 1, 4'b0000, 32'h1234_5678,
                    4'b0010, 32'h1234_5678, 4, 3, 1'b0};
        vecs[1] = '{32'h0300_0000, 4'b0011, 32'hA5A5_5A5A, 1, 0, 4'b0000,
                    32'h0000_1111, 4'b0001, 32'h0000_1111, 2, 1, 1'b0};
        vecs[2] = '{32'h0900_0000, 4'h0, 32'h0, 0, 0, 4'b0000, 32'h0,
                    4'b0000, 32'hDEAD_BEEF, 1, 0, 1'b1};
        vecs[3] = '{32'h0500_0004, 4'h0, 32'h0, 0, 2, 4'b0000, 32'h7777_7777,
                    4'b0100, 32'hDEAD_BEEF, 9, 8, 1'b1};
        vecs[4] = '{32'h0500_0008, 4'h0, 32'h0, 8, 2, 4'b0000, 32'hCAFE_F00D,
                    4'b0100, 32'hCAFE_F00D, 9, 8, 1'b0};
        vecs[5] = '{32'h0600_00FC, 4'b1111, 32'h0102_0304, 2, 3, 4'b0000,
                    32'h0BAD_F00D, 4'b1000, 32'h0BAD_F00D, 3, 2, 1'b0};
        vecs[6] = '{32'h0400_0020, 4'h0, 32'h0, 0, 1, 4'b1101, 32'h1111_2222,
                    4'b0010, 32'hDEAD_BEEF, 9, 8, 1'b1};
        vecs[7] = '{32'h0000_0000, 4'b1111, 32'hFFFF_0000, 0, 0, 4'b0000, 32'h0,
                    4'b0000, 32'hDEAD_BEEF, 1, 0, 1'b1};
        vecs[8] = '{32'h0300_0044, 4'h0, 32'h0, 5, 0, 4'b1110, 32'h5A5A_0044,
                    4'b0001, 32'h5A5A_0044, 6, 5, 1'b0};

        reset     = 1'b1;
        m_valid   = 1'b0;
        m_wstrb   = '0;
        m_addr    = '0;
        m_wdata   = '0;
        s_ready   = '0;
        s_rdata   = '0;
        err_clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_ready", 32'(m_ready), 32'd0);
        chk("rst_m_rdata", m_rdata, 32'd0);
        chk("rst_s_valid", 32'(s_valid), 32'd0);
        chk("rst_s_addr", s_addr, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        reset = 1'b0;

        for (int k = 0; k < 9; k++) do_txn(vecs[k]);

        for (int k = 0; k < 300; k++) fast_unmapped();
        exp_cnt = 255;
        chk("err_count_sat", 32'(err_count), 32'hFF);

        @(negedge clk);
        m_valid   = 1'b1;
        m_addr    = 32'h0A00_0000;
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        m_valid   = 1'b0;
        exp_cnt   = 1;
        chk("clear_with_err_count", 32'(err_count), 32'd1);
        chk("clear_with_err_pulse", 32'(err_pulse), 32'd1);
        chk("clear_with_err_addr", err_addr, 32'h0A00_0000);
        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        exp_cnt   = 0;
        chk("clear_alone", 32'(err_count), 32'd0);

        @(negedge clk);
        m_valid = 1'b1;
        m_addr  = 32'h0300_0000;
        m_wstrb = 4'h0;
        @(negedge clk);
        chk("pre_reset_s_valid", 32'(s_valid), 32'b0001);
        m_valid = 1'b0;
        reset   = 1'b1;
        #1;
        chk("async_rst_s_valid", 32'(s_valid), 32'd0);
        chk("async_rst_m_ready", 32'(m_ready), 32'd0);
        chk("async_rst_s_addr", s_addr, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_txn('{32'h0500_0000, 4'h0, 32'h0, 1, 2, 4'b0000, 32'h55AA_0001,
                 4'b0100, 32'h55AA_0001, 2, 1, 1'b0});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
